ws2812_write_arbiter: RTL and testbench
=======================================

WS2812_WRITE_ARBITER -- requirements
Module: ws2812_write_arbiter

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LEDs in the downstream ws2812 chain; valid range 1..256.
REQ-002 clk  input  1  system clock; all logic is rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_a  input  1  requester A write request; level, held until ack_a.
REQ-005 num_a  input  8  requester A LED index; stable while req_a is high.
REQ-006 rgb_a  input  24  requester A colour; stable while req_a is high.
REQ-007 ack_a  output  1  one-cycle pulse; requester A's request has been consumed.
REQ-008 req_b, num_b, rgb_b, ack_b SHALL match REQ-004..REQ-007 for requester B.
REQ-009 fill_req  input  1  single-cycle pulse; start a whole-chain fill.
REQ-010 fill_rgb  input  24  fill colour; sampled only on the edge that accepts fill_req.
REQ-011 fill_busy  output  1  high during every fill write cycle.
REQ-012 fill_done  output  1  one-cycle pulse, coincident with the last fill write.
REQ-013 write  output  1  write strobe to the ws2812 driver's write port.
REQ-014 led_num  output  8  LED index to the driver.
REQ-015 rgb_data  output  24  colour to the driver.

Function
REQ-016 All outputs SHALL be registered; write, ack_a, ack_b and fill_done SHALL be single-cycle pulses.
REQ-017 States SHALL be IDLE and FILL only.
REQ-018 IDLE, fill_req high: accept the fill; fill_req SHALL take priority over req_a and req_b on the same edge.
REQ-019 IDLE, no fill_req: grant at most one eligible requester per edge.
REQ-020 Grant latency: a request sampled on edge N SHALL produce write=1 (if in range) and ack=1 in the cycle after edge N.
REQ-021 A requester acked in the current cycle SHALL be ineligible on the next edge, to prevent a double grant of a held request.
REQ-022 If both requesters are eligible, grant the one not granted most recently (round-robin); after reset A SHALL win the first tie.
REQ-023 Granted request with num >= NUM_LEDS: ack pulses, write stays 0, and led_num/rgb_data hold their previous values.
REQ-024 Granted in-range request: led_num = num_x and rgb_data = rgb_x in the write cycle.
REQ-025 Fill accepted on edge E: write=1 and fill_busy=1 for exactly NUM_LEDS consecutive cycles after E, with led_num = 0, 1, ..., NUM_LEDS-1 and rgb_data = latched fill_rgb.
REQ-026 fill_done SHALL pulse in the led_num = NUM_LEDS-1 cycle; the state returns to IDLE on the edge that ends that cycle.
REQ-027 In FILL: no acks; req_a/req_b stall and are arbitrated on the first IDLE edge; fill_req is ignored and not queued.
REQ-028 The fill index counter SHALL be 8 bits and SHALL NOT wrap past NUM_LEDS-1.
REQ-029 When not writing, write SHALL be 0; the round-robin pointer updates only on a grant.

Reset
REQ-030 While reset is high on an edge: state=IDLE; write, ack_a, ack_b, fill_busy and fill_done all 0; led_num=0; rgb_data=0; pointer favours A.
REQ-031 Reset during FILL SHALL abort the fill with no further writes and no fill_done pulse.
REQ-032 Requests held through reset SHALL be arbitrated normally from the first edge with reset low.

Verification
REQ-033 NUM_LEDS=8; req_a=1, num_a=3, rgb_a=0xFF0000 from edge 1 -> cycle 2: write=1, led_num=3, rgb_data=0xFF0000, ack_a=1; requester drops req -> no further writes.
REQ-034 req_a and req_b held high continuously, both in range -> acks alternate A, B, A, B starting with A; no requester acked in two consecutive cycles.
REQ-035 fill_req with fill_rgb=0x00FF00 -> 8 write cycles, led_num 0..7, fill_busy high throughout, fill_done only with led_num=7; req_b raised mid-fill is acked in the second cycle after fill_busy falls.
REQ-036 req_b with num_b=9 -> ack_b pulses, write stays 0.
REQ-037 fill_req and req_a on the same edge -> fill runs first; ack_a follows the fill completion.
REQ-038 reset asserted when led_num=4 during a fill -> write=0 on the next cycle, fill_done never pulses, state=IDLE.

Source files
------------

// File: rtl/ws2812_write_arbiter_if.sv
// Request, fill and driver-write signals between two requesters, a fill source and the arbiter.
// The arbiter takes the slave modport. Requesters, the fill source and the driver sit on the master side.
interface ws2812_write_arbiter_if;
   logic        req_a;
   logic [7:0]  num_a;
   logic [23:0] rgb_a;
   logic        ack_a;
   logic        req_b;
   logic [7:0]  num_b;
   logic [23:0] rgb_b;
   logic        ack_b;
   logic        fill_req;
   logic [23:0] fill_rgb;
   logic        fill_busy;
   logic        fill_done;
   logic        write;
   logic [7:0]  led_num;
   logic [23:0] rgb_data;

   modport slave (
      input  req_a, num_a, rgb_a, req_b, num_b, rgb_b, fill_req, fill_rgb,
      output ack_a, ack_b, fill_busy, fill_done, write, led_num, rgb_data
   );

   modport master (
      output req_a, num_a, rgb_a, req_b, num_b, rgb_b, fill_req, fill_rgb,
      input  ack_a, ack_b, fill_busy, fill_done, write, led_num, rgb_data
   );
endinterface

// File: rtl/ws2812_write_arbiter.sv
// Round-robin arbiter for two ws2812 write requesters plus a whole-chain fill; all outputs registered.
// A grant shows one cycle after the request is sampled. Requests stall, with no ack, while a fill runs.
module ws2812_write_arbiter #(
   parameter int NUM_LEDS = 8
) (
   input logic                  clk,
   input logic                  reset,
   ws2812_write_arbiter_if.slave bus
);

   localparam logic [7:0] LAST  = 8'(NUM_LEDS - 1);
   localparam logic [8:0] LIMIT = 9'(NUM_LEDS);

   typedef enum logic {IDLE, FILL} state_t;

   state_t      state, state_nxt;
   logic        write_q, write_d;
   logic        ack_a_q, ack_a_d;
   logic        ack_b_q, ack_b_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  led_q, led_d;
   logic [7:0]  idx_q, idx_d;
   logic [23:0] rgb_q, rgb_d;
   logic        prio_b_q, prio_b_d;

   logic elig_a, elig_b, pick_a, pick_b, range_a, range_b;

   // A requester still showing its ack holds a request already consumed.
   assign elig_a  = bus.req_a & ~ack_a_q;
   assign elig_b  = bus.req_b & ~ack_b_q;
   assign pick_a  = elig_a & (~elig_b | ~prio_b_q);
   assign pick_b  = elig_b & ~pick_a;
   assign range_a = {1'b0, bus.num_a} < LIMIT;
   assign range_b = {1'b0, bus.num_b} < LIMIT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_q  <= 1'b0;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         led_q    <= 8'd0;
         idx_q    <= 8'd0;
         rgb_q    <= 24'd0;
         prio_b_q <= 1'b0;
      end else begin
         write_q  <= write_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         led_q    <= led_d;
         idx_q    <= idx_d;
         rgb_q    <= rgb_d;
         prio_b_q <= prio_b_d;
      end
   end

   always_comb begin
      state_nxt = state;
      write_d   = 1'b0;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      led_d     = led_q;
      idx_d     = idx_q;
      rgb_d     = rgb_q;
      prio_b_d  = prio_b_q;

      case (state)
         IDLE: begin
            if (bus.fill_req) begin
               state_nxt = FILL;
               write_d   = 1'b1;
               busy_d    = 1'b1;
               done_d    = (LAST == 8'd0);
               idx_d     = 8'd0;
               led_d     = 8'd0;
               rgb_d     = bus.fill_rgb;
            end else if (pick_a) begin
               ack_a_d  = 1'b1;
               prio_b_d = 1'b1;
               if (range_a) begin
                  write_d = 1'b1;
                  led_d   = bus.num_a;
                  rgb_d   = bus.rgb_a;
               end
            end else if (pick_b) begin
               ack_b_d  = 1'b1;
               prio_b_d = 1'b0;
               if (range_b) begin
                  write_d = 1'b1;
                  led_d   = bus.num_b;
                  rgb_d   = bus.rgb_b;
               end
            end
         end

         FILL: begin
            // rgb_q still carries the colour captured when the fill was accepted.
            if (idx_q == LAST) begin
               state_nxt = IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               led_d   = idx_q + 8'd1;
               write_d = 1'b1;
               busy_d  = 1'b1;
               done_d  = ((idx_q + 8'd1) == LAST);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign bus.write     = write_q;
   assign bus.ack_a     = ack_a_q;
   assign bus.ack_b     = ack_b_q;
   assign bus.fill_busy = busy_q;
   assign bus.fill_done = done_q;
   assign bus.led_num   = led_q;
   assign bus.rgb_data  = rgb_q;

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Scoreboarded bench for ws2812_write_arbiter (NUM_LEDS = 8).
// Expected writes are queued at stimulus time and checked by a monitor whenever write is high.
module tb_ws2812_write_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   bad;

   typedef struct {
      logic [7:0]  led;
      logic [23:0] rgb;
   } wr_t;

   wr_t exp_q[$];

   ws2812_write_arbiter_if bus_if ();

   ws2812_write_arbiter #(.NUM_LEDS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (bus_if.write === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: led=%0d rgb=%06h, none expected", bus_if.led_num, bus_if.rgb_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus_if.led_num !== e.led || bus_if.rgb_data !== e.rgb) begin
               bad++;
               $display("FAIL write_data: got led=%0d rgb=%06h want led=%0d rgb=%06h",
                        bus_if.led_num, bus_if.rgb_data, e.led, e.rgb);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] led, input logic [23:0] rgb);
      wr_t e;
      e.led = led;
      e.rgb = rgb;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      checks++;
      if ({bus_if.write, bus_if.ack_a, bus_if.ack_b, bus_if.fill_busy, bus_if.fill_done} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %05b want 00000",
                  {bus_if.write, bus_if.ack_a, bus_if.ack_b, bus_if.fill_busy, bus_if.fill_done});
      end
      checks++;
      if (bus_if.led_num !== 8'd0) begin
         bad++;
         $display("FAIL reset_led: got %0d want 0", bus_if.led_num);
      end
      checks++;
      if (bus_if.rgb_data !== 24'd0) begin
         bad++;
         $display("FAIL reset_rgb: got %06h want 000000", bus_if.rgb_data);
      end
      reset = 1'b0;
      step();
      checks++;
      if (bus_if.write !== 1'b0) begin
         bad++;
         $display("FAIL idle_write: got %b want 0", bus_if.write);
      end
   endtask

   task automatic test_single();
      bus_if.req_a = 1'b1;
      bus_if.num_a = 8'd3;
      bus_if.rgb_a = 24'hFF0000;
      push(8'd3, 24'hFF0000);
      step();
      checks++;
      if ({bus_if.write, bus_if.ack_a, bus_if.ack_b} !== 3'b110) begin
         bad++;
         $display("FAIL single_grant: got w/a/b=%03b want 110", {bus_if.write, bus_if.ack_a, bus_if.ack_b});
      end
      bus_if.req_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({bus_if.write, bus_if.ack_a} !== 2'b00) begin
            bad++;
            $display("FAIL single_quiet: cycle %0d got w/a=%02b want 00", i, {bus_if.write, bus_if.ack_a});
         end
      end
   endtask

   task automatic test_round_robin();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus_if.req_a = 1'b1;
      bus_if.num_a = 8'd1;
      bus_if.rgb_a = 24'h111111;
      bus_if.req_b = 1'b1;
      bus_if.num_b = 8'd2;
      bus_if.rgb_b = 24'h222222;
      for (int i = 0; i < 3; i++) begin
         push(8'd1, 24'h111111);
         push(8'd2, 24'h222222);
      end
      for (int i = 0; i < 6; i++) begin
         logic exp_a;
         step();
         exp_a = (i % 2 == 0);
         checks++;
         if (bus_if.ack_a !== exp_a || bus_if.ack_b !== !exp_a) begin
            bad++;
            $display("FAIL rr_order: grant %0d got a=%b b=%b want a=%b b=%b",
                     i, bus_if.ack_a, bus_if.ack_b, exp_a, !exp_a);
         end
      end
      bus_if.req_a = 1'b0;
      bus_if.req_b = 1'b0;
      step();
   endtask

   task automatic test_fill();
      bus_if.fill_req = 1'b1;
      bus_if.fill_rgb = 24'h00FF00;
      for (int i = 0; i < 8; i++) push(8'(i), 24'h00FF00);
      step();
      bus_if.fill_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({bus_if.write, bus_if.fill_busy, bus_if.fill_done, bus_if.ack_b} !== {2'b11, (i == 7), 1'b0}) begin
            bad++;
            $display("FAIL fill_cycle: idx %0d got w/busy/done/ackb=%04b want %04b", i,
                     {bus_if.write, bus_if.fill_busy, bus_if.fill_done, bus_if.ack_b}, {2'b11, (i == 7), 1'b0});
         end
         if (i == 3) begin
            bus_if.req_b = 1'b1;
            bus_if.num_b = 8'd5;
            bus_if.rgb_b = 24'h0000AA;
            push(8'd5, 24'h0000AA);
         end
         if (i == 5) begin
            bus_if.fill_req = 1'b1;
            bus_if.fill_rgb = 24'hFFFFFF;
         end
         if (i == 6) bus_if.fill_req = 1'b0;
         step();
      end
      checks++;
      if ({bus_if.write, bus_if.fill_busy, bus_if.fill_done, bus_if.ack_b} !== 4'b0000) begin
         bad++;
         $display("FAIL fill_end: got w/busy/done/ackb=%04b want 0000",
                  {bus_if.write, bus_if.fill_busy, bus_if.fill_done, bus_if.ack_b});
      end
      step();
      checks++;
      if ({bus_if.write, bus_if.ack_b} !== 2'b11) begin
         bad++;
         $display("FAIL fill_stalled_b: got w/ackb=%02b want 11", {bus_if.write, bus_if.ack_b});
      end
      bus_if.req_b = 1'b0;
      step();
   endtask

   task automatic test_out_of_range();
      bus_if.req_b = 1'b1;
      bus_if.num_b = 8'd9;
      bus_if.rgb_b = 24'h123456;
      step();
      checks++;
      if ({bus_if.write, bus_if.ack_b} !== 2'b01) begin
         bad++;
         $display("FAIL oor_ack: got w/ackb=%02b want 01", {bus_if.write, bus_if.ack_b});
      end
      checks++;
      if (bus_if.led_num !== 8'd5 || bus_if.rgb_data !== 24'h0000AA) begin
         bad++;
         $display("FAIL oor_hold: got led=%0d rgb=%06h want led=5 rgb=0000aa", bus_if.led_num, bus_if.rgb_data);
      end
      bus_if.req_b = 1'b0;
      step();
   endtask

   task automatic test_fill_priority();
      bus_if.fill_req = 1'b1;
      bus_if.fill_rgb = 24'h0A0B0C;
      bus_if.req_a    = 1'b1;
      bus_if.num_a    = 8'd6;
      bus_if.rgb_a    = 24'hABCDEF;
      for (int i = 0; i < 8; i++) push(8'(i), 24'h0A0B0C);
      push(8'd6, 24'hABCDEF);
      step();
      bus_if.fill_req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         checks++;
         if ({bus_if.fill_busy, bus_if.ack_a} !== {(i < 8), 1'b0}) begin
            bad++;
            $display("FAIL prio_fill: cycle %0d got busy/acka=%02b want %02b", i,
                     {bus_if.fill_busy, bus_if.ack_a}, {(i < 8), 1'b0});
         end
         step();
      end
      checks++;
      if ({bus_if.write, bus_if.ack_a} !== 2'b11) begin
         bad++;
         $display("FAIL prio_then_a: got w/acka=%02b want 11", {bus_if.write, bus_if.ack_a});
      end
      bus_if.req_a = 1'b0;
      step();
   endtask

   task automatic test_reset_in_fill();
      bus_if.fill_req = 1'b1;
      bus_if.fill_rgb = 24'h777777;
      for (int i = 0; i < 5; i++) push(8'(i), 24'h777777);
      step();
      bus_if.fill_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus_if.write !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: idx %0d got write=%b want 1", i, bus_if.write);
         end
         if (i == 4) reset = 1'b1;
         step();
      end
      checks++;
      if ({bus_if.write, bus_if.fill_busy, bus_if.fill_done} !== 3'b000 || bus_if.led_num !== 8'd0) begin
         bad++;
         $display("FAIL abort_state: got w/busy/done=%03b led=%0d want 000 led=0",
                  {bus_if.write, bus_if.fill_busy, bus_if.fill_done}, bus_if.led_num);
      end
      bus_if.req_a = 1'b1;
      bus_if.num_a = 8'd7;
      bus_if.rgb_a = 24'h00C0DE;
      push(8'd7, 24'h00C0DE);
      step();
      checks++;
      if ({bus_if.write, bus_if.ack_a} !== 2'b00) begin
         bad++;
         $display("FAIL held_in_reset: got w/acka=%02b want 00", {bus_if.write, bus_if.ack_a});
      end
      reset = 1'b0;
      step();
      checks++;
      if ({bus_if.write, bus_if.ack_a} !== 2'b11) begin
         bad++;
         $display("FAIL held_after_reset: got w/acka=%02b want 11", {bus_if.write, bus_if.ack_a});
      end
      bus_if.req_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if ({bus_if.write, bus_if.fill_done} !== 2'b00) begin
            bad++;
            $display("FAIL abort_quiet: cycle %0d got w/done=%02b want 00", i, {bus_if.write, bus_if.fill_done});
         end
      end
   endtask

   initial begin
      checks          = 0;
      bad             = 0;
      reset           = 1'b1;
      bus_if.req_a    = 1'b0;
      bus_if.num_a    = 8'd0;
      bus_if.rgb_a    = 24'd0;
      bus_if.req_b    = 1'b0;
      bus_if.num_b    = 8'd0;
      bus_if.rgb_b    = 24'd0;
      bus_if.fill_req = 1'b0;
      bus_if.fill_rgb = 24'd0;

      test_reset();
      test_single();
      test_round_robin();
      test_fill();
      test_out_of_range();
      test_fill_priority();
      test_reset_in_fill();

      checks++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_writes: got %0d unconsumed want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule
